seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: one shift-and-subtract iteration per clock.

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle between the pipeline and
// the sequential divider coprocessor.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one shift-and-subtract step per clock,
// started by a start pulse and reporting results with a one-cycle done pulse.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // the extra bit exists only in the shifted/trial values.
    assign w_rem_shift = {r_rem, r_q[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_divisor};
    assign w_fits      = ~w_trial[WIDTH];
    assign w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
    assign w_q_next    = {r_q[WIDTH-2:0], w_fits};
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = (bus.divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && (bus.divisor == '0)) begin
                        r_quotient  <= '1;
                        r_remainder <= bus.dividend;
                        r_dbz       <= 1'b1;
                    end else if (bus.start) begin
                        r_rem     <= '0;
                        r_q       <= bus.dividend;
                        r_divisor <= bus.divisor;
                        r_cnt     <= '0;
                        r_dbz     <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Visible results move only on the edge that enters DONE.
                    if (w_last) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider latency, results, divide-by-zero,
// start filtering, back-to-back operation and asynchronous reset.
module tb_seq_divider;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive an operation into IDLE and drop start just after the accepting edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Negedges from the accepting edge until done is seen; 999 when it never comes.
    task automatic wait_done(output int lat);
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_vec++; if (bus.quotient !== 16'h0) begin n_err++; $display("FAIL reset_q: got %h want 0000", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'h0) begin n_err++; $display("FAIL reset_r: got %h want 0000", bus.remainder); end
        n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        launch(16'd100, 16'd7);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_run: got %b want 1", bus.busy); end
        wait_done(lat);
        n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 1); end
        n_vec++; if (bus.quotient !== 16'd14) begin n_err++; $display("FAIL basic_q: got %0d want 14", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'd2) begin n_err++; $display("FAIL basic_r: got %0d want 2", bus.remainder); end
        n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_done: got %b want 1", bus.busy); end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", bus.done); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_idle: got %b want 0", bus.busy); end
        n_vec++; if (bus.quotient !== 16'd14) begin n_err++; $display("FAIL basic_q_hold: got %0d want 14", bus.quotient); end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] va [5] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd0, 16'd1000};
        logic [W-1:0] vb [5] = '{16'd1,    16'd9, 16'hFFFF, 16'd5, 16'd3};
        logic [W-1:0] vq [5] = '{16'hFFFF, 16'd0, 16'd1,    16'd0, 16'd333};
        logic [W-1:0] vr [5] = '{16'd0,    16'd5, 16'd0,    16'd0, 16'd1};
        int lat;
        for (int i = 0; i < 5; i++) begin
            launch(va[i], vb[i]);
            wait_done(lat);
            n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL bound_lat[%0d]: got %0d want %0d", i, lat, W + 1); end
            n_vec++; if (bus.quotient !== vq[i]) begin n_err++; $display("FAIL bound_q[%0d]: got %h want %h", i, bus.quotient, vq[i]); end
            n_vec++; if (bus.remainder !== vr[i]) begin n_err++; $display("FAIL bound_r[%0d]: got %h want %h", i, bus.remainder, vr[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        launch(16'h1234, 16'd0);
        wait_done(lat);
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_vec++; if (bus.quotient !== 16'hFFFF) begin n_err++; $display("FAIL dz_q: got %h want ffff", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'h1234) begin n_err++; $display("FAIL dz_r: got %h want 1234", bus.remainder); end
        n_vec++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", bus.div_by_zero); end
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL dz_busy: got %b want 1", bus.busy); end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL dz_done_pulse: got %b want 0", bus.done); end
        n_vec++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag_hold: got %b want 1", bus.div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int lat;
        int pulses;
        launch(16'd100, 16'd7);
        lat = 999;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            bus.start = (i >= 3 && i <= 5);
            if (i == 3) begin
                bus.dividend = 16'd1000;
                bus.divisor  = 16'd3;
            end
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
        n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL ign_latency: got %0d want %0d", lat, W + 1); end
        n_vec++; if (bus.quotient !== 16'd14) begin n_err++; $display("FAIL ign_q: got %0d want 14", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'd2) begin n_err++; $display("FAIL ign_r: got %0d want 2", bus.remainder); end
        n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL ign_dbz: got %b want 0", bus.div_by_zero); end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL ign_extra_done: got %0d want 0", pulses); end
        n_vec++; if (bus.quotient !== 16'd14) begin n_err++; $display("FAIL ign_q_hold: got %0d want 14", bus.quotient); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd200;
        bus.divisor  = 16'd9;
        @(posedge clk);
        #1;
        bus.dividend = 16'd77;
        bus.divisor  = 16'd4;
        wait_done(lat);
        n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL b2b_lat1: got %0d want %0d", lat, W + 1); end
        n_vec++; if (bus.quotient !== 16'd22) begin n_err++; $display("FAIL b2b_q1: got %0d want 22", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'd2) begin n_err++; $display("FAIL b2b_r1: got %0d want 2", bus.remainder); end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_gap_done: got %b want 0", bus.done); end
        wait_done(lat);
        bus.start = 1'b0;
        n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL b2b_lat2: got %0d want %0d", lat, W + 1); end
        n_vec++; if (bus.quotient !== 16'd19) begin n_err++; $display("FAIL b2b_q2: got %0d want 19", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'd1) begin n_err++; $display("FAIL b2b_r2: got %0d want 1", bus.remainder); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses;
        launch(16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL async_done: got %b want 0", bus.done); end
        n_vec++; if (bus.quotient !== 16'h0) begin n_err++; $display("FAIL async_q: got %h want 0000", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'h0) begin n_err++; $display("FAIL async_r: got %h want 0000", bus.remainder); end
        n_vec++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL async_dbz: got %b want 0", bus.div_by_zero); end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL abort_stale_done: got %0d active cycles want 0", pulses); end
        launch(16'd50, 16'd5);
        wait_done(lat);
        n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL abort_lat: got %0d want %0d", lat, W + 1); end
        n_vec++; if (bus.quotient !== 16'd10) begin n_err++; $display("FAIL abort_q: got %0d want 10", bus.quotient); end
        n_vec++; if (bus.remainder !== 16'd0) begin n_err++; $display("FAIL abort_r: got %0d want 0", bus.remainder); end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  recon;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom);
            b = (k % 2 == 1) ? W'($urandom_range(1, 255)) : W'($urandom_range(1, 65535));
            launch(a, b);
            wait_done(lat);
            recon = 32'(bus.quotient) * 32'(b) + 32'(bus.remainder);
            n_vec++; if (lat != W + 1) begin n_err++; $display("FAIL rnd_lat %h/%h: got %0d want %0d", a, b, lat, W + 1); end
            n_vec++; if (recon !== 32'(a)) begin n_err++; $display("FAIL rnd_recon %h/%h: got q=%h r=%h (%h) want %h", a, b, bus.quotient, bus.remainder, recon, a); end
            n_vec++; if (!(bus.remainder < b)) begin n_err++; $display("FAIL rnd_rem_bound %h/%h: got r=%h want below %h", a, b, bus.remainder, b); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
